// File: rtl/prog_sequencer.sv
// prog_sequencer: multi-cycle FETCH/EXEC/MEMWAIT sequencer owning the program counter.
// Ports:
//   Clk, Reset_n          clock (rising edge) and asynchronous active-low reset
//   Start, StartAddr      begin a run at StartAddr (honoured only in IDLE or DONE)
//   ProgEnd               address of the last instruction; its commit ends the run
//   Opcode                instr[8:6] from the instruction ROM
//   BranchTaken, BrOffset branch decision and signed 6-bit offset
//   MemAck                data memory completion strobe
//   PC                    current program counter
//   IFetch                instruction ROM read strobe
//   RegWriteEn            register file write qualifier, high only in commit cycles
//   MemReq                data memory request level
//   Busy, Done            run in progress / run complete (held until next Start)
//   CycleCount            busy cycles of the current or last run, saturating
module prog_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic [PC_W-1:0]  ProgEnd,
  input  logic [2:0]       Opcode,
  input  logic             BranchTaken,
  input  logic [5:0]       BrOffset,
  input  logic             MemAck,
  output logic [PC_W-1:0]  PC,
  output logic             IFetch,
  output logic             RegWriteEn,
  output logic             MemReq,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMWAIT, DONE} state_t;
  state_t state;
  logic is_mem, is_br, commit, at_end;
  logic [PC_W-1:0] pc_next;
  assign is_mem = Opcode[2:1] == 2'b00;
  assign is_br = Opcode == 3'b111;
  // Commit happens in EXEC for non-memory ops, or in the MemAck cycle of MEMWAIT.
  assign commit = (state == EXEC && !is_mem) || (state == MEMWAIT && MemAck);
  assign at_end = PC == ProgEnd;
  assign pc_next = (state == EXEC && is_br && BranchTaken)
                 ? PC + {{(PC_W-6){BrOffset[5]}}, BrOffset}
                 : PC + 1'b1;
  assign Busy = state == FETCH || state == EXEC || state == MEMWAIT;
  assign IFetch = state == FETCH;
  assign MemReq = (state == EXEC && is_mem) || state == MEMWAIT;
  assign RegWriteEn = (state == EXEC && !is_mem && !is_br) ||
                      (state == MEMWAIT && MemAck && Opcode == 3'b000);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      PC <= '0;
      CycleCount <= '0;
      Done <= 1'b0;
    end else begin
      if (Busy && CycleCount != '1) CycleCount <= CycleCount + 1'b1;
      if ((state == IDLE || state == DONE) && Start) begin
        state <= FETCH;
        PC <= StartAddr;
        CycleCount <= '0;
        Done <= 1'b0;
      end else if (state == FETCH) state <= EXEC;
      else if (state == EXEC && is_mem) state <= MEMWAIT;
      else if (commit) begin
        PC <= pc_next;
        state <= at_end ? DONE : FETCH;
        Done <= at_end;
      end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: table-driven cycle-by-cycle check of prog_sequencer plus a mid-MEMWAIT reset sequence.
module tb_prog_sequencer;
  logic Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, BranchTaken = 1'b0, MemAck = 1'b0;
  logic [9:0] StartAddr = '0, ProgEnd = '0, PC;
  logic [2:0] Opcode = '0;
  logic [5:0] BrOffset = '0;
  logic IFetch, RegWriteEn, MemReq, Busy, Done;
  logic [15:0] CycleCount;
  int n_chk = 0, n_fail = 0;

  prog_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr), .ProgEnd(ProgEnd),
    .Opcode(Opcode), .BranchTaken(BranchTaken), .BrOffset(BrOffset), .MemAck(MemAck),
    .PC(PC), .IFetch(IFetch), .RegWriteEn(RegWriteEn), .MemReq(MemReq), .Busy(Busy),
    .Done(Done), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // flags = {IFetch, RegWriteEn, MemReq, Busy, Done}
  localparam int IDL = 'b00000, DN = 'b00001, FE = 'b10010, EX = 'b00010;
  localparam int EXW = 'b01010, MR = 'b00110, MRW = 'b01110;
  localparam int LDR = 0, STR = 1, ADD = 2, BR = 7;

  typedef struct {
    logic st; logic [9:0] sa, pe; logic [2:0] op; logic bt; logic [5:0] off; logic ack;
    logic [9:0] pc; logic [4:0] fl; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(int st, int sa, int pe, int op, int bt, int off, int ack,
                              int pc, int fl, int cnt);
    vec_t r;
    r.st = 1'(st); r.sa = 10'(sa); r.pe = 10'(pe); r.op = 3'(op); r.bt = 1'(bt);
    r.off = 6'(off); r.ack = 1'(ack); r.pc = 10'(pc); r.fl = 5'(fl); r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic chk(string name, logic [9:0] pc_e, logic [4:0] fl_e, logic [15:0] cnt_e);
    logic [4:0] fl;
    fl = {IFetch, RegWriteEn, MemReq, Busy, Done};
    n_chk++;
    if (PC !== pc_e || fl !== fl_e || CycleCount !== cnt_e) begin
      n_fail++;
      $display("FAIL %s: got pc=%h flags=%b cnt=%0d, expected pc=%h flags=%b cnt=%0d",
               name, PC, fl, CycleCount, pc_e, fl_e, cnt_e);
    end
  endtask

  vec_t v [38];

  initial begin
    // run 1: three ADDR from 0, ProgEnd=2
    v[0]  = mk(0, 0, 0, 0, 0, 0, 0,      0, IDL, 0);
    v[1]  = mk(1, 0, 2, 0, 0, 0, 0,      0, IDL, 0);
    v[2]  = mk(0, 0, 2, ADD, 0, 0, 0,    0, FE, 0);
    v[3]  = mk(0, 0, 2, ADD, 0, 0, 0,    0, EXW, 1);
    v[4]  = mk(0, 0, 2, ADD, 0, 0, 0,    1, FE, 2);
    v[5]  = mk(0, 0, 2, ADD, 0, 0, 0,    1, EXW, 3);
    v[6]  = mk(0, 0, 2, ADD, 0, 0, 0,    2, FE, 4);
    v[7]  = mk(0, 0, 2, ADD, 0, 0, 0,    2, EXW, 5);
    v[8]  = mk(0, 0, 2, ADD, 0, 0, 0,    3, DN, 6);
    v[9]  = mk(0, 0, 2, ADD, 0, 0, 0,    3, DN, 6);
    // runs 2/3: BR at ProgEnd=5, offset -3, taken then not taken
    v[10] = mk(1, 5, 5, BR, 1, -3, 0,    3, DN, 6);
    v[11] = mk(0, 5, 5, BR, 1, -3, 0,    5, FE, 0);
    v[12] = mk(0, 5, 5, BR, 1, -3, 0,    5, EX, 1);
    v[13] = mk(1, 5, 5, BR, 0, -3, 0,    2, DN, 2);
    v[14] = mk(0, 5, 5, BR, 0, -3, 0,    5, FE, 0);
    v[15] = mk(0, 5, 5, BR, 0, -3, 0,    5, EX, 1);
    // run 4: LDR then STR, each acked on the 3rd MEMWAIT cycle; ack in EXEC ignored
    v[16] = mk(1, 20, 21, LDR, 0, 0, 0,  6, DN, 2);
    v[17] = mk(0, 20, 21, LDR, 0, 0, 0,  20, FE, 0);
    v[18] = mk(0, 20, 21, LDR, 0, 0, 1,  20, MR, 1);
    v[19] = mk(0, 20, 21, LDR, 0, 0, 0,  20, MR, 2);
    v[20] = mk(0, 20, 21, LDR, 0, 0, 0,  20, MR, 3);
    v[21] = mk(0, 20, 21, LDR, 0, 0, 1,  20, MRW, 4);
    v[22] = mk(0, 20, 21, STR, 0, 0, 0,  21, FE, 5);
    v[23] = mk(0, 20, 21, STR, 0, 0, 1,  21, MR, 6);
    v[24] = mk(0, 20, 21, STR, 0, 0, 0,  21, MR, 7);
    v[25] = mk(0, 20, 21, STR, 0, 0, 0,  21, MR, 8);
    v[26] = mk(0, 20, 21, STR, 0, 0, 1,  21, MR, 9);
    // run 5: Start pulsed in EXEC and FETCH is ignored
    v[27] = mk(1, 30, 31, ADD, 0, 0, 0,  22, DN, 10);
    v[28] = mk(0, 30, 31, ADD, 0, 0, 0,  30, FE, 0);
    v[29] = mk(1, 100, 31, ADD, 0, 0, 0, 30, EXW, 1);
    v[30] = mk(1, 100, 31, ADD, 0, 0, 0, 31, FE, 2);
    v[31] = mk(0, 100, 31, ADD, 0, 0, 0, 31, EXW, 3);
    // run 6: start from DONE at 3FF, ProgEnd=0, PC wraps
    v[32] = mk(1, 'h3FF, 0, ADD, 0, 0, 0, 32, DN, 4);
    v[33] = mk(0, 'h3FF, 0, ADD, 0, 0, 0, 'h3FF, FE, 0);
    v[34] = mk(0, 'h3FF, 0, ADD, 0, 0, 0, 'h3FF, EXW, 1);
    v[35] = mk(0, 'h3FF, 0, ADD, 0, 0, 0, 0, FE, 2);
    v[36] = mk(0, 'h3FF, 0, ADD, 0, 0, 0, 0, EXW, 3);
    v[37] = mk(0, 'h3FF, 0, ADD, 0, 0, 0, 1, DN, 4);

    repeat (2) @(negedge Clk);
    #1 chk("reset", 0, IDL, 0);
    @(negedge Clk) Reset_n = 1'b1;
    for (int i = 0; i < 38; i++) begin
      @(negedge Clk);
      Start = v[i].st; StartAddr = v[i].sa; ProgEnd = v[i].pe; Opcode = v[i].op;
      BranchTaken = v[i].bt; BrOffset = v[i].off; MemAck = v[i].ack;
      #1 chk($sformatf("vec%0d", i), v[i].pc, v[i].fl, v[i].cnt);
    end

    // LDR run from 40; reset asserted between edges while MemAck is high in MEMWAIT
    @(negedge Clk);
    Start = 1'b1; StartAddr = 10'd40; ProgEnd = 10'd50; Opcode = 3'b000; MemAck = 1'b0;
    @(negedge Clk) Start = 1'b0;
    #1 chk("ldr_fetch", 40, FE, 0);
    @(negedge Clk);
    #1 chk("ldr_exec", 40, MR, 1);
    @(negedge Clk) MemAck = 1'b1;
    #1 chk("memwait_ack", 40, MRW, 2);
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", 0, IDL, 0);
    @(negedge Clk);
    #1 chk("held_reset", 0, IDL, 0);
    @(negedge Clk) Reset_n = 1'b1;
    #1 chk("reset_release", 0, IDL, 0);
    @(negedge Clk);
    #1 chk("no_commit", 0, IDL, 0);
    MemAck = 1'b0;
    @(negedge Clk);
    #1 chk("idle_after", 0, IDL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Multi-cycle instruction sequencer for the 9-bit/3-bit-opcode core. It owns the program counter and runs a FETCH/EXEC/MEMWAIT state machine. It gates the register-file write enable to the single commit cycle of each instruction. It also handshakes with the data memory and brackets a program run with Start/Done. It sits between the instruction ROM, the control decoder (which supplies Branch) and the data memory.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
CNT_W, 16, width of the run cycle counter.

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  begin a run; sampled only in IDLE or DONE.
StartAddr  in  PC_W  first instruction address of the run.
ProgEnd  in  PC_W  address of the last instruction; the run ends when it commits.
Opcode  in  3  instr[8:6] from the instruction ROM; valid during EXEC and MEMWAIT.
BranchTaken  in  1  Branch output of the control decoder; valid in EXEC.
BrOffset  in  6  signed branch offset (immed6).
MemAck  in  1  data memory completion strobe.
PC  out  PC_W  current program counter.
IFetch  out  1  instruction ROM read strobe.
RegWriteEn  out  1  register file write qualifier.
MemReq  out  1  data memory request, level.
Busy  out  1  high while a run is in progress.
Done  out  1  run complete; held until the next Start.
CycleCount  out  CNT_W  cycles spent in the current or last run.

Behaviour:
- Reset (Reset_n=0, async, any state): state=IDLE, PC=0, CycleCount=0, all strobes and Done=0.
  - Reset mid-run drops MemReq immediately; no commit happens.
- States: IDLE, FETCH, EXEC, MEMWAIT, DONE. Busy=1 exactly in FETCH, EXEC and MEMWAIT.
- IDLE/DONE with Start=1: PC<=StartAddr, CycleCount<=0, Done<=0, next=FETCH. Start=0: remain.
- Start in any busy state: ignored.
- FETCH (1 cycle): IFetch=1, next=EXEC.
- EXEC, Opcode 000 (LDR) or 001 (STR):
  - MemReq=1, RegWriteEn=0, PC unchanged, next=MEMWAIT.
  - MemAck is ignored in EXEC.
- EXEC, Opcode 111 (BR) — commit cycle:
  - RegWriteEn=0.
  - BranchTaken=1: PC<=PC+sext(BrOffset).
  - BranchTaken=0: PC<=PC+1.
- EXEC, Opcodes 010–110 — commit cycle: RegWriteEn=1, PC<=PC+1.
- MEMWAIT: MemReq=1 held until MemAck=1. The MemAck cycle is the commit cycle:
  - RegWriteEn=1 if Opcode=000, else 0.
  - PC<=PC+1.
  - MemReq deasserts the following cycle.
  - There is no timeout.
- After a commit: if the pre-update PC==ProgEnd then next=DONE with Done<=1, else next=FETCH.
  - A branch at ProgEnd still ends the run.
- PC arithmetic is modulo 2^PC_W; wrap 2^PC_W-1 -> 0 is legal.
  - Negative offsets are sign-extended from bit 5.
- CycleCount increments by 1 in every cycle where Busy=1 and saturates at all-ones.
  - It holds its value in DONE.
- Outputs are Moore-style from state except:
  - RegWriteEn and the PC update depend on Opcode, BranchTaken and MemAck in the current cycle.
- At most one RegWriteEn pulse per instruction; never asserted in FETCH, IDLE or DONE.

Test Plan:
- Reset_n low mid-MEMWAIT -> MemReq, Busy and RegWriteEn fall asynchronously; PC=0; state IDLE; no further commit.
- StartAddr=0, ProgEnd=2, three ADDR (010) -> RegWriteEn pulses in cycles 2, 4 and 6; Done rises after cycle 6; CycleCount=6; PC=3.
- BR at PC=5, BranchTaken=1, BrOffset=6'b111101 (-3) -> PC=2 and RegWriteEn=0. Same with BranchTaken=0 -> PC=6.
- LDR with MemAck on the 3rd MEMWAIT cycle -> MemReq high for 4 cycles; one RegWriteEn in the ack cycle; instruction takes 5 cycles. STR with the same timing -> RegWriteEn stays 0.
- Start pulsed during EXEC -> ignored; PC and CycleCount unaffected.
- Start in DONE with StartAddr=10'h3FF, ProgEnd=10'h000, two ADDR -> PC wraps 3FF->000; Done after 4 cycles; CycleCount restarts from 0.
